// File: rtl/forth_loader.sv
// forth_loader
// Boot/program loader for the forth core. While a program image is streamed in
// over a byte link, the core is held in reset. The image is written word by word
// into instruction memory starting at address 0. A trailing XOR checksum is then
// checked, and the core is released only when it matches.
//
// Frame: LEN_LO LEN_HI (word count N, little-endian), N x (DATA_LO DATA_HI),
//        CSUM (XOR of every preceding byte of the frame).
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low
//   rx_data      in   incoming byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader accepts a byte (transfer = rx_valid & rx_ready)
//   start        in   1-cycle pulse, (re)starts a load from any state
//   imem_addr    out  imem write address
//   imem_wdata   out  imem write data
//   imem_we      out  imem write strobe, one cycle per word
//   cpu_reset    out  active-high reset to the forth core, low only in RUN
//   busy         out  a frame is being received (LEN_LO..CSUM)
//   error        out  length or checksum error, held until start
//   words_loaded out  words written by the current/last load
module forth_loader #(
    parameter int IADDR_WIDTH = 10,
    parameter bit AUTOBOOT    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   start,
    output logic [IADDR_WIDTH-1:0] imem_addr,
    output logic [15:0]            imem_wdata,
    output logic                   imem_we,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   error,
    output logic [IADDR_WIDTH:0]   words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << IADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM, S_RUN, S_ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [7:0]             lo_q, lo_d;
    logic [7:0]             csum_q, csum_d;
    logic [IADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic [IADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   cpu_rst_q, cpu_rst_d;
    logic                   xfer;
    logic [16:0]            n_word;

    // Ready is decoded from the registered state only, so it never depends on rx_valid.
    assign rx_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                      (state_q == S_CSUM);
    assign busy         = rx_ready;
    assign error        = (state_q == S_ERROR);
    assign xfer         = rx_valid & rx_ready;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign imem_we      = we_q;
    assign cpu_reset    = cpu_rst_q;
    assign words_loaded = wcnt_q;

    // Full word count as it completes in LEN_HI, widened so 2**IADDR_WIDTH compares cleanly.
    assign n_word = {1'b0, rx_data, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lo_d    = lo_q;
        csum_d  = csum_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;

        if (start) begin
            // A restart abandons any partial image; written words stay in imem.
            state_d = S_LEN_LO;
            csum_d  = 8'h00;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (AUTOBOOT) begin
                        state_d = S_LEN_LO;
                        csum_d  = 8'h00;
                        wcnt_d  = '0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_d[7:0] = rx_data;
                        csum_d     = csum_q ^ rx_data;
                        state_d    = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_d[15:8] = rx_data;
                        csum_d      = csum_q ^ rx_data;
                        if (n_word == 17'd0)
                            state_d = S_CSUM;
                        else if (n_word > MAX_WORDS)
                            state_d = S_ERROR;
                        else
                            state_d = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (xfer) begin
                        lo_d    = rx_data;
                        csum_d  = csum_q ^ rx_data;
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (xfer) begin
                        csum_d  = csum_q ^ rx_data;
                        we_d    = 1'b1;
                        addr_d  = wcnt_q[IADDR_WIDTH-1:0];
                        wdata_d = {rx_data, lo_q};
                        wcnt_d  = wcnt_q + (IADDR_WIDTH+1)'(1);
                        // Count reaches N on the last word; address therefore never wraps.
                        if (17'(wcnt_q) + 17'd1 == {1'b0, len_q})
                            state_d = S_CSUM;
                        else
                            state_d = S_DATA_LO;
                    end
                end
                S_CSUM: begin
                    if (xfer)
                        state_d = (rx_data == csum_q) ? S_RUN : S_ERROR;
                end
                default: begin
                    // RUN and ERROR hold until start.
                end
            endcase
        end

        cpu_rst_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            len_q     <= 16'h0000;
            lo_q      <= 8'h00;
            csum_q    <= 8'h00;
            wcnt_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            we_q      <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            lo_q      <= lo_d;
            csum_q    <= csum_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

endmodule

// File: tb/tb_forth_loader.sv
module tb_forth_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        start;
    logic [9:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_we;
    logic        cpu_reset;
    logic        busy;
    logic        error;
    logic [10:0] words_loaded;

    int tests = 0;
    int fails = 0;

    // Scoreboard entries: {addr, data, words_loaded at the strobe}.
    logic [36:0] exp_q[$];
    logic [36:0] obs_q[$];
    int          rd_ptr = 0;
    logic [7:0]  frm[$];

    always #5 clk = ~clk;

    forth_loader #(.IADDR_WIDTH(10), .AUTOBOOT(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .imem_we      (imem_we),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always @(negedge clk)
        if (imem_we === 1'b1) obs_q.push_back({imem_addr, imem_wdata, words_loaded});

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        rx_valid = 1'b0;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        cnt = 0;
        while (rx_ready !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (rx_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL byte_accept timeout: rx_ready=%b required 1 (byte %h)", rx_ready, b);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        foreach (frm[i]) send_byte(frm[i], (maxgap == 0) ? 0 : int'($urandom_range(1, maxgap)));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_frame1_writes();
        exp_q.push_back({10'd0, 16'h1234, 11'd1});
        exp_q.push_back({10'd1, 16'h8001, 11'd2});
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0;
        #23;
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
        tests++; if (imem_addr !== 10'd0) begin fails++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
        tests++; if (imem_wdata !== 16'h0) begin fails++; $display("FAIL reset_imem_wdata: got %h want 0", imem_wdata); end
        tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        tests++; if (busy !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL reset_busy_error: got %b%b want 00", busy, error); end
        tests++; if (words_loaded !== 11'd0) begin fails++; $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (rx_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL autoboot_len_lo: rx_ready/busy got %b%b want 11", rx_ready, busy); end
    endtask

    task automatic test_frame_ok();
        logic [36:0] e;
        frm = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'h80};
        push_frame1_writes();
        send_frame(0);
        tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL ok_cpu_reset_before_csum: got %b want 1", cpu_reset); end
        send_byte(8'hA5, 0);
        tests++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL ok_cpu_reset_after_csum: got %b want 0", cpu_reset); end
        tests++; if (words_loaded !== 11'd2) begin fails++; $display("FAIL ok_words_loaded: got %0d want 2", words_loaded); end
        tests++; if (error !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin fails++; $display("FAIL ok_run_flags: err/busy/rdy got %b%b%b want 000", error, busy, rx_ready); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (rd_ptr >= obs_q.size()) begin fails++; $display("FAIL ok_write missing: got none want %h", e); end
            else begin if (obs_q[rd_ptr] !== e) begin fails++; $display("FAIL ok_write: got %h want %h", obs_q[rd_ptr], e); end rd_ptr++; end
        end
        tests++; if (obs_q.size() != rd_ptr) begin fails++; $display("FAIL ok_extra_writes: got %0d want %0d", obs_q.size(), rd_ptr); rd_ptr = obs_q.size(); end
    endtask

    task automatic test_bad_csum();
        logic [36:0] e;
        frm = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'h80, 8'hA4};
        pulse_start();
        tests++; if (cpu_reset !== 1'b1 || words_loaded !== 11'd0) begin fails++; $display("FAIL bad_restart: cpu_reset/words got %b/%0d want 1/0", cpu_reset, words_loaded); end
        push_frame1_writes();
        send_frame(0);
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL bad_error: got %b want 1", error); end
        tests++; if (cpu_reset !== 1'b1 || rx_ready !== 1'b0) begin fails++; $display("FAIL bad_hold: cpu_reset/rx_ready got %b%b want 10", cpu_reset, rx_ready); end
        repeat (3) @(posedge clk); #1;
        tests++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin fails++; $display("FAIL bad_sticky: error/cpu_reset got %b%b want 11", error, cpu_reset); end
        pulse_start();
        tests++; if (error !== 1'b0 || rx_ready !== 1'b1) begin fails++; $display("FAIL bad_start_clears: error/rx_ready got %b%b want 01", error, rx_ready); end
        frm = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'h80, 8'hA5};
        push_frame1_writes();
        send_frame(0);
        tests++; if (cpu_reset !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL bad_reload_run: cpu_reset/error got %b%b want 00", cpu_reset, error); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (rd_ptr >= obs_q.size()) begin fails++; $display("FAIL bad_write missing: got none want %h", e); end
            else begin if (obs_q[rd_ptr] !== e) begin fails++; $display("FAIL bad_write: got %h want %h", obs_q[rd_ptr], e); end rd_ptr++; end
        end
        tests++; if (obs_q.size() != rd_ptr) begin fails++; $display("FAIL bad_extra_writes: got %0d want %0d", obs_q.size(), rd_ptr); rd_ptr = obs_q.size(); end
    endtask

    task automatic test_empty();
        frm = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_frame(0);
        tests++; if (cpu_reset !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL empty_run: cpu_reset/error got %b%b want 00", cpu_reset, error); end
        tests++; if (words_loaded !== 11'd0) begin fails++; $display("FAIL empty_words: got %0d want 0", words_loaded); end
        repeat (2) @(posedge clk); #1;
        tests++; if (obs_q.size() != rd_ptr) begin fails++; $display("FAIL empty_writes: got %0d want %0d", obs_q.size(), rd_ptr); rd_ptr = obs_q.size(); end
    endtask

    task automatic test_too_long();
        frm = '{8'h01, 8'h04};
        pulse_start();
        send_frame(0);
        tests++; if (error !== 1'b1 || rx_ready !== 1'b0) begin fails++; $display("FAIL long_error: error/rx_ready got %b%b want 10", error, rx_ready); end
        tests++; if (cpu_reset !== 1'b1 || words_loaded !== 11'd0) begin fails++; $display("FAIL long_hold: cpu_reset/words got %b/%0d want 1/0", cpu_reset, words_loaded); end
        repeat (2) @(posedge clk); #1;
        tests++; if (obs_q.size() != rd_ptr) begin fails++; $display("FAIL long_writes: got %0d want %0d", obs_q.size(), rd_ptr); rd_ptr = obs_q.size(); end
    endtask

    task automatic test_gaps();
        logic [36:0] e;
        frm = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'h80, 8'hA5};
        pulse_start();
        push_frame1_writes();
        send_frame(5);
        tests++; if (cpu_reset !== 1'b0 || words_loaded !== 11'd2) begin fails++; $display("FAIL gaps_run: cpu_reset/words got %b/%0d want 0/2", cpu_reset, words_loaded); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (rd_ptr >= obs_q.size()) begin fails++; $display("FAIL gaps_write missing: got none want %h", e); end
            else begin if (obs_q[rd_ptr] !== e) begin fails++; $display("FAIL gaps_write: got %h want %h", obs_q[rd_ptr], e); end rd_ptr++; end
        end
        tests++; if (obs_q.size() != rd_ptr) begin fails++; $display("FAIL gaps_extra_writes: got %0d want %0d", obs_q.size(), rd_ptr); rd_ptr = obs_q.size(); end
    endtask

    task automatic test_max_len();
        logic [36:0] e;
        logic [15:0] w;
        logic [7:0]  cs;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        cs = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w = 16'(i * 40503 + 7);
            exp_q.push_back({10'(i), w, 11'(i + 1)});
            send_byte(w[7:0], 0);
            send_byte(w[15:8], 0);
            cs = cs ^ w[7:0] ^ w[15:8];
        end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL max_in_csum: busy got %b want 1", busy); end
        send_byte(cs, 0);
        tests++; if (cpu_reset !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL max_run: cpu_reset/error got %b%b want 00", cpu_reset, error); end
        tests++; if (words_loaded !== 11'd1024 || imem_addr !== 10'h3FF) begin fails++; $display("FAIL max_end: words/addr got %0d/%h want 1024/3ff", words_loaded, imem_addr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (rd_ptr >= obs_q.size()) begin fails++; $display("FAIL max_write missing: got none want %h", e); end
            else begin if (obs_q[rd_ptr] !== e) begin fails++; $display("FAIL max_write: got %h want %h", obs_q[rd_ptr], e); end rd_ptr++; end
        end
        tests++; if (obs_q.size() != rd_ptr) begin fails++; $display("FAIL max_extra_writes: got %0d want %0d", obs_q.size(), rd_ptr); rd_ptr = obs_q.size(); end
    endtask

    task automatic test_restart();
        logic [36:0] e;
        pulse_start();
        frm = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01};
        exp_q.push_back({10'd0, 16'h1234, 11'd1});
        send_frame(0);
        tests++; if (words_loaded !== 11'd1) begin fails++; $display("FAIL restart_partial: words got %0d want 1", words_loaded); end
        pulse_start();
        tests++; if (words_loaded !== 11'd0 || busy !== 1'b1 || cpu_reset !== 1'b1) begin fails++; $display("FAIL restart_clear: words/busy/cpu_reset got %0d/%b/%b want 0/1/1", words_loaded, busy, cpu_reset); end
        frm = '{8'h01, 8'h00, 8'hCD, 8'hAB, 8'h67};
        exp_q.push_back({10'd0, 16'hABCD, 11'd1});
        send_frame(0);
        tests++; if (cpu_reset !== 1'b0 || error !== 1'b0 || words_loaded !== 11'd1) begin fails++; $display("FAIL restart_run: cpu_reset/error/words got %b/%b/%0d want 0/0/1", cpu_reset, error, words_loaded); end
        pulse_start();
        frm = '{8'h02, 8'h00, 8'h34};
        send_frame(0);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        tests++; if (rx_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL areset_flags: rdy/busy/err got %b%b%b want 000", rx_ready, busy, error); end
        tests++; if (cpu_reset !== 1'b1 || imem_we !== 1'b0) begin fails++; $display("FAIL areset_cpu: cpu_reset/we got %b%b want 10", cpu_reset, imem_we); end
        tests++; if (imem_addr !== 10'd0 || imem_wdata !== 16'h0 || words_loaded !== 11'd0) begin fails++; $display("FAIL areset_regs: addr/data/words got %h/%h/%0d want 0/0/0", imem_addr, imem_wdata, words_loaded); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        frm = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'h80, 8'hA5};
        push_frame1_writes();
        send_frame(0);
        tests++; if (cpu_reset !== 1'b0 || words_loaded !== 11'd2) begin fails++; $display("FAIL areset_reload: cpu_reset/words got %b/%0d want 0/2", cpu_reset, words_loaded); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (rd_ptr >= obs_q.size()) begin fails++; $display("FAIL restart_write missing: got none want %h", e); end
            else begin if (obs_q[rd_ptr] !== e) begin fails++; $display("FAIL restart_write: got %h want %h", obs_q[rd_ptr], e); end rd_ptr++; end
        end
        tests++; if (obs_q.size() != rd_ptr) begin fails++; $display("FAIL restart_extra_writes: got %0d want %0d", obs_q.size(), rd_ptr); rd_ptr = obs_q.size(); end
    endtask

    initial begin
        test_reset();
        test_frame_ok();
        test_bad_csum();
        test_empty();
        test_too_long();
        test_gaps();
        test_max_len();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
